tt_um_willow240_spi_regs: RTL and testbench
===========================================

# tt_um_willow240_spi_regs

SPI-target register block in the standard Tiny Tapeout user-project wrapper. It sits behind the chip's dedicated and bidirectional pins. An external SPI host (or the cocotb bench) reads and writes four 8-bit registers over a mode-0 SPI link on `ui_in`. The registers control an 8-bit counter and the `uio` pads, so the design is fully exercisable from the pin level.

## Interface
- No parameters; register count (4) and frame length (16 bits) are fixed.
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ena`  in  1  design-selected; ignored, design runs regardless
- `ui_in`  in  8  [0]=SCLK, [1]=CS_N, [2]=MOSI, [7:3] unused
- `uo_out`  out  8  [0]=MISO, [7:1]=REG1[6:0]
- `uio_in`  in  8  sampled into REG3
- `uio_out`  out  8  REG2 (counter) value
- `uio_oe`  out  8  all bits = REG0[1]

## Operation
- SCLK, CS_N and MOSI each pass through a 2-flop synchronizer. A third flop on SCLK gives one-cycle `sclk_rise`/`sclk_fall` strobes.
- SPI mode 0, MSB first, 16-bit frame:
  - bit15 = W (1 = write, 0 = read)
  - bits14:8 = address; only [9:8] decoded, [14:10] ignored
  - bits7:0 = write data, or don't-care for reads
- FSM states:
  - IDLE: bit counter = 0, MISO = 0. Synced CS_N falling -> ADDR.
  - ADDR: shift MOSI on each `sclk_rise`. After the 8th rise, latch W/addr and snapshot the addressed register into the TX shift register -> DATA.
  - DATA: shift MOSI on each rise; on each `sclk_fall` drive the next TX bit to MISO, MSB first. The first fall in DATA drives TX[7]. After the 16th rise -> DONE.
  - DONE: if W=1, commit data to the addressed register in this cycle. Further SCLK edges are ignored until CS_N rises -> IDLE.
- Synced CS_N rising in any state -> IDLE next cycle. No commit happens unless the state is DONE.
- Registers:
  - REG0 ctrl (R/W): [0] counter enable, [1] uio output enable, [7:2] stored and readable but unused.
  - REG1 (R/W): drives `uo_out[7:1]` = REG1[6:0].
  - REG2 counter (R/W): +1 every clk while REG0[0]=1, 8-bit wrap 255->0. An SPI write in the same cycle wins over the increment.
  - REG3 (RO): `uio_in` resampled every clk; writes are discarded.
- A read returns the value snapshotted at end of ADDR, not the value at the time each bit shifts out.

## Timing
- Reset values: all registers 0, FSM IDLE, TX/RX shift registers 0, `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0x00.
- Pin-to-strobe latency is 3 clk (2 synchronizer flops + edge detect).
- MISO settles ≤4 clk after a pad SCLK fall.
- Host constraints:
  - SCLK low ≥5 clk and high ≥4 clk.
  - CS_N setup before the first SCLK rise ≥4 clk; CS_N hold after the 16th rise ≥5 clk.
- Write commit: the register updates 1 clk after the 16th `sclk_rise`, i.e. 4 clk after the pad edge. `uo_out`/`uio_out`/`uio_oe` reflect the new value in the same cycle, since they are driven directly from the register flops.
- REG3 lags `uio_in` by 1 clk.
- Reset asserted mid-frame: everything returns to reset values immediately, with no partial commit. After deassert, the FSM waits in IDLE for a fresh CS_N fall.

## Test plan
- Reset, then read all four addresses -> REG0..REG2 read 0x00, REG3 reads the driven `uio_in` (e.g. 0xA5); `uo_out`=0x00, `uio_oe`=0x00.
- Write REG1=0xFF via frame 0x81FF -> `uo_out[7:1]`=0x7F. Then read REG1 via frame 0x0100 -> MISO shifts out 0xFF.
- Write REG2=0xFE, then REG0=0x03 -> `uio_oe`=0xFF and `uio_out` counts 0xFE, 0xFF, 0x00, 0x01 on consecutive clks (wrap check).
- Counter running, write REG2=0x10 -> that cycle loads 0x10, the next cycle shows 0x11 (write beats increment).
- Raise CS_N after 12 bits of write frame 0x8155 -> REG1 unchanged. A following full frame 0x8133 still works and gives REG1=0x33.
- Write REG3 with 0x8300 while `uio_in`=0x3C -> REG3 still reads 0x3C. A 24-bit frame 0x8177xx -> REG1=0x77 and extra bits are ignored.

Source files
------------

// File: rtl/tt_um_willow240_spi_regs.sv
// SPI mode-0 target exposing four 8-bit registers in the Tiny Tapeout wrapper.
// REG0 is control, REG1 drives uo_out[7:1], REG2 is a free-running counter on
// uio_out, and REG3 is a read-only resample of uio_in. A frame is 16 bits, MSB
// first: {W, addr[6:0], data[7:0]}. Only addr[1:0] is decoded.
module tt_um_willow240_spi_regs (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Synchronizer chains; bit 0 is the flop nearest the pad.
    logic [2:0] sclk_sync_r;
    logic [2:0] cs_sync_r;
    logic [1:0] mosi_sync_r;

    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       cs_rise_s;
    logic       cs_fall_s;

    state_t     state_r;
    state_t     state_s;

    logic [3:0] bit_cnt_r;
    logic [7:0] rx_r;
    logic [7:0] rx_next_s;
    logic [7:0] tx_r;
    logic       w_r;
    logic [1:0] addr_r;
    logic       miso_r;
    logic       commit_r;

    logic       shift_s;
    logic       tx_shift_s;
    logic       latch_addr_s;
    logic       last_bit_s;
    logic       commit_s;
    logic [7:0] reg_rd_s;

    logic [7:0] reg0_r;
    logic [7:0] reg1_r;
    logic [7:0] reg2_r;
    logic [7:0] reg3_r;

    logic       unused_s;

    // ena is ignored and ui_in[7:3] carry nothing for this design.
    assign unused_s = &{1'b0, ena, ui_in[7:3]};

    // Bring SCLK, CS_N and MOSI into the clk domain. CS_N resets low so that a
    // host already holding CS_N low at reset release is not seen as a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b000;
            mosi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], ui_in[0]};
            cs_sync_r   <= {cs_sync_r[1:0], ui_in[1]};
            mosi_sync_r <= {mosi_sync_r[0], ui_in[2]};
        end
    end

    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
    assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];

    assign rx_next_s    = {rx_r[6:0], mosi_sync_r[1]};
    assign shift_s      = ((state_r == ST_ADDR) || (state_r == ST_DATA)) && sclk_rise_s && !cs_rise_s;
    assign tx_shift_s   = (state_r == ST_DATA) && sclk_fall_s && !cs_rise_s;
    assign latch_addr_s = shift_s && (state_r == ST_ADDR) && (bit_cnt_r == 4'd7);
    assign last_bit_s   = shift_s && (state_r == ST_DATA) && (bit_cnt_r == 4'd15);
    // Commit only while actually sitting in DONE; a frame cut short never gets here.
    assign commit_s     = commit_r && (state_r == ST_DONE);

    // Next-state logic; a CS_N rise aborts from anywhere.
    always_comb begin
        state_s = state_r;
        if (cs_rise_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_s = ST_ADDR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (latch_addr_s) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (last_bit_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Read mux for the snapshot taken at the end of the address byte.
    always_comb begin
        reg_rd_s = 8'h00;
        case (rx_next_s[1:0])
            2'd0:    reg_rd_s = reg0_r;
            2'd1:    reg_rd_s = reg1_r;
            2'd2:    reg_rd_s = reg2_r;
            2'd3:    reg_rd_s = reg3_r;
            default: reg_rd_s = 8'h00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bit counter and MOSI receive shifter; RX ends up holding the data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 4'd0;
            rx_r      <= 8'h00;
        end else if (state_r == ST_IDLE) begin
            bit_cnt_r <= 4'd0;
            rx_r      <= rx_r;
        end else if (shift_s) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            rx_r      <= rx_next_s;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            rx_r      <= rx_r;
        end
    end

    // Latch W/address and snapshot the addressed register; shift TX on falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r    <= 1'b0;
            addr_r <= 2'd0;
            tx_r   <= 8'h00;
        end else if (latch_addr_s) begin
            w_r    <= rx_next_s[7];
            addr_r <= rx_next_s[1:0];
            tx_r   <= reg_rd_s;
        end else if (tx_shift_s) begin
            w_r    <= w_r;
            addr_r <= addr_r;
            tx_r   <= {tx_r[6:0], 1'b0};
        end else begin
            w_r    <= w_r;
            addr_r <= addr_r;
            tx_r   <= tx_r;
        end
    end

    // MISO carries TX MSB-first during DATA and is held low otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_r <= 1'b0;
        end else if (tx_shift_s) begin
            miso_r <= tx_r[7];
        end else if (state_r != ST_DATA) begin
            miso_r <= 1'b0;
        end else begin
            miso_r <= miso_r;
        end
    end

    // Arm the write commit for the first DONE cycle after the 16th rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_r <= 1'b0;
        end else begin
            commit_r <= last_bit_s && w_r;
        end
    end

    // Register file; an SPI write to REG2 takes priority over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg0_r <= 8'h00;
            reg1_r <= 8'h00;
            reg2_r <= 8'h00;
            reg3_r <= 8'h00;
        end else begin
            reg3_r <= uio_in;
            if (commit_s && (addr_r == 2'd0)) begin
                reg0_r <= rx_r;
            end else begin
                reg0_r <= reg0_r;
            end
            if (commit_s && (addr_r == 2'd1)) begin
                reg1_r <= rx_r;
            end else begin
                reg1_r <= reg1_r;
            end
            if (commit_s && (addr_r == 2'd2)) begin
                reg2_r <= rx_r;
            end else if (reg0_r[0]) begin
                reg2_r <= reg2_r + 8'd1;
            end else begin
                reg2_r <= reg2_r;
            end
        end
    end

    assign uo_out  = {reg1_r[6:0], miso_r};
    assign uio_out = reg2_r;
    assign uio_oe  = {8{reg0_r[1]}};

endmodule

// File: tb/tb_tt_um_willow240_spi_regs.sv
// Bench for tt_um_willow240_spi_regs: drives SPI frames at pin level with
// randomized SCLK timing and compares the pins against a register-level model.
module tb_tt_um_willow240_spi_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {5'b00000, mosi, cs_n, sclk};

    always #5 clk = ~clk;

    tt_um_willow240_spi_regs dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    int         n_checks = 0;
    int         n_pass   = 0;

    // Model state: the four registers plus scheduled snapshot/commit cycles.
    logic [7:0] m_reg [4];
    int         cyc       = 0;
    int         pend_at   = -1;
    logic [1:0] pend_addr = 2'd0;
    logic [7:0] pend_data = 8'h00;
    int         snap_at   = -1;
    logic [1:0] snap_addr = 2'd0;
    logic [7:0] snap_val  = 8'h00;
    int         seq_len   = 0;
    logic [7:0] seq_vals [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge of the model, then compare the pins against it.
    task automatic model_edge();
        logic [7:0] nxt2;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        end else begin
            if (cyc == snap_at) snap_val = m_reg[snap_addr];
            nxt2 = m_reg[2] + (m_reg[0][0] ? 8'd1 : 8'd0);
            if (cyc == pend_at) begin
                case (pend_addr)
                    2'd0:    m_reg[0] = pend_data;
                    2'd1:    m_reg[1] = pend_data;
                    2'd2:    nxt2 = pend_data;
                    default: ;
                endcase
            end
            m_reg[2] = nxt2;
            m_reg[3] = uio_in;
        end
        chk("pins", {9'd0, uo_out[7:1], uio_out, uio_oe},
            {9'd0, m_reg[1][6:0], m_reg[2], {8{m_reg[0][1]}}});
        if (seq_len > 0 && pend_at >= 0 && cyc >= pend_at && cyc < pend_at + seq_len)
            chk("count_seq", {24'd0, uio_out}, {24'd0, seq_vals[cyc - pend_at]});
    endtask

    // Host-side frame. frame is MSB-aligned; bit i goes out as frame[23-i].
    task automatic spi_xfer(input logic [23:0] frame, input int nbits, input bit live,
                            input bit do_fall, input bit end_cs, output logic [7:0] rd);
        int lo;
        int hi;
        rd = 8'h00;
        if (do_fall) begin
            @(negedge clk);
            cs_n = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            lo = $urandom_range(7, 5);
            hi = $urandom_range(6, 4);
            @(negedge clk);
            sclk = 1'b0;
            mosi = frame[23 - i];
            repeat (lo) @(negedge clk);
            if (i >= 8 && i < 16) rd = {rd[6:0], uo_out[0]};
            sclk = 1'b1;
            if (live && i == 7) begin
                snap_addr = frame[17:16];
                snap_at   = cyc + 3;
            end
            if (live && i == 15 && frame[23]) begin
                pend_addr = frame[17:16];
                pend_data = frame[15:8];
                pend_at   = cyc + 4;
            end
            repeat (hi - 1) @(negedge clk);
        end
        @(negedge clk);
        sclk = 1'b0;
        if (end_cs) begin
            repeat (2) @(negedge clk);
            cs_n = 1'b1;
            repeat ($urandom_range(8, 4)) @(negedge clk);
            chk("miso_idle", {31'd0, uo_out[0]}, 32'd0);
        end
    endtask

    task automatic write_frame(input logic [15:0] f);
        logic [7:0] rd;
        spi_xfer({f, 8'h00}, 16, 1'b1, 1'b1, 1'b1, rd);
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [7:0] exp, input string name);
        logic [7:0] rd;
        spi_xfer({1'b0, 5'd0, a, 8'h00, 8'h00}, 16, 1'b1, 1'b1, 1'b1, rd);
        chk(name, {24'd0, rd}, {24'd0, exp});
        chk({name, "_model"}, {24'd0, snap_val}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] rd;
        rst_n  = 1'b0;
        ena    = 1'b1;
        sclk   = 1'b0;
        cs_n   = 1'b1;
        mosi   = 1'b0;
        uio_in = 8'hA5;
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;

        fork
            forever begin
                @(posedge clk);
                #1;
                model_edge();
            end
        join_none

        // Reset state and reads of every address.
        repeat (3) @(negedge clk);
        chk("reset_pins", {8'd0, uo_out, uio_out, uio_oe}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        read_reg(2'd0, 8'h00, "rd_reg0_rst");
        read_reg(2'd1, 8'h00, "rd_reg1_rst");
        read_reg(2'd2, 8'h00, "rd_reg2_rst");
        read_reg(2'd3, 8'hA5, "rd_reg3_rst");

        // REG1 drives uo_out[7:1] and reads back.
        write_frame(16'h81FF);
        chk("uo_hi_7f", {25'd0, uo_out[7:1]}, {25'd0, 7'h7F});
        read_reg(2'd1, 8'hFF, "rd_reg1_ff");

        // Counter wrap once enabled, with uio output enable.
        write_frame(16'h82FE);
        seq_vals[0] = 8'hFE; seq_vals[1] = 8'hFF; seq_vals[2] = 8'h00; seq_vals[3] = 8'h01;
        seq_len = 4;
        write_frame(16'h8003);
        seq_len = 0;
        chk("uio_oe_ff", {24'd0, uio_oe}, {24'd0, 8'hFF});

        // A write to the running counter wins over the increment.
        seq_vals[0] = 8'h10; seq_vals[1] = 8'h11;
        seq_len = 2;
        write_frame(16'h8210);
        seq_len = 0;

        // Aborted frame leaves REG1 untouched; the next full frame works.
        spi_xfer({16'h8155, 8'h00}, 12, 1'b1, 1'b1, 1'b1, rd);
        read_reg(2'd1, 8'hFF, "rd_reg1_abort");
        write_frame(16'h8133);
        read_reg(2'd1, 8'h33, "rd_reg1_33");

        // REG3 is read-only; long frames commit on the 16th bit only.
        @(negedge clk);
        uio_in = 8'h3C;
        write_frame(16'h8300);
        read_reg(2'd3, 8'h3C, "rd_reg3_ro");
        spi_xfer({16'h8177, 8'hC3}, 24, 1'b1, 1'b1, 1'b1, rd);
        read_reg(2'd1, 8'h77, "rd_reg1_24b");

        // Reset mid-frame; CS_N held low across release must not start a frame.
        spi_xfer({16'h81AA, 8'h00}, 10, 1'b1, 1'b1, 1'b0, rd);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_pins", {8'd0, uo_out, uio_out, uio_oe}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        spi_xfer({16'h81AA, 8'h00}, 16, 1'b0, 1'b0, 1'b1, rd);
        read_reg(2'd1, 8'h00, "rd_reg1_norestart");
        read_reg(2'd2, 8'h00, "rd_reg2_norestart");

        // Randomized frames: reads checked against the model snapshot.
        for (int k = 0; k < 40; k++) begin
            logic [23:0] f;
            int          nb;
            @(negedge clk);
            uio_in = 8'($urandom);
            f      = 24'($urandom);
            nb     = (k % 7 == 3) ? 12 : ((k % 5 == 4) ? 24 : 16);
            spi_xfer(f, nb, 1'b1, 1'b1, 1'b1, rd);
            if (!f[23] && nb >= 16) chk("rand_read", {24'd0, rd}, {24'd0, snap_val});
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
